exec_sequencer: RTL

- Sequential successor to the single-shot matrix instruction decoder.
- Fetches instruction words from instruction memory, starting at a programmable PC, and decodes the matrix opcodes SUM/SUB/MUL/SCA/TRA/STOP.
- Dispatches each decoded operation to the matrix functional units over a valid/ready issue port, waits for completion, then advances.
- Runs until STOP or an illegal opcode; address width is parametrised.

---
 rtl/exec_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/exec_sequencer.sv
// Sequential matrix-instruction fetch/decode/issue engine: FETCH -> DECODE -> ISSUE -> WAIT until STOP or illegal opcode.
// Optional WAIT watchdog enabled by defining EXEC_SEQ_TIMEOUT_EN.
module exec_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 1024,
  localparam int INSTR_W = 4 + 2 + ADDR_W + 2 * (1 + ADDR_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [PC_W-1:0]    start_pc,
  output logic               instr_rd,
  output logic [PC_W-1:0]    instr_addr,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic               instr_valid,
  output logic               op_valid,
  input  logic               op_ready,
  output logic [4:0]         op_unit,
  output logic [1:0]         dst_sel,
  output logic [ADDR_W-1:0]  dst_addr,
  output logic [ADDR_W-1:0]  src1_addr,
  output logic [ADDR_W-1:0]  src2_addr,
  output logic               src1_sel,
  output logic               src2_sel,
  output logic [7:0]         scalar,
  input  logic               op_done,
  output logic               busy,
  output logic               halted,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [15:0]        retired
);

  localparam int SRC_W = 2 * (1 + ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_HALT, S_ERR
  } state_t;

  state_t              state;
  logic [PC_W-1:0]     pc;
  logic [INSTR_W-1:0]  instr_q;

  logic [3:0]          f_opcode;
  logic [1:0]          f_dst_sel;
  logic [ADDR_W-1:0]   f_dst_addr;
  logic                f_src1_sel;
  logic [ADDR_W-1:0]   f_src1_addr;
  logic                f_src2_sel;
  logic [ADDR_W-1:0]   f_src2_addr;
  logic [7:0]          f_scalar;
  logic [4:0]          unit_onehot;
  logic [15:0]         retired_inc;

  assign f_opcode    = instr_q[INSTR_W-1 -: 4];
  assign f_dst_sel   = instr_q[INSTR_W-5 -: 2];
  assign f_dst_addr  = instr_q[INSTR_W-7 -: ADDR_W];
  assign f_src1_sel  = instr_q[2*ADDR_W+1];
  assign f_src1_addr = instr_q[2*ADDR_W -: ADDR_W];
  assign f_src2_sel  = instr_q[ADDR_W];
  assign f_src2_addr = instr_q[ADDR_W-1:0];
  // SCA reuses the top byte of the whole source region as its multiplier.
  assign f_scalar    = instr_q[SRC_W-1 -: 8];

  assign instr_addr  = pc;
  assign retired_inc = (retired == 16'hFFFF) ? retired : retired + 16'd1;

  always_comb begin
    unit_onehot = 5'b00000;
    case (f_opcode)
      4'd1: unit_onehot = 5'b00001;
      4'd2: unit_onehot = 5'b00010;
      4'd3: unit_onehot = 5'b00100;
      4'd4: unit_onehot = 5'b01000;
      4'd5: unit_onehot = 5'b10000;
      default: unit_onehot = 5'b00000;
    endcase
  end

`ifdef EXEC_SEQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CNT_W-1:0] wait_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      instr_q   <= '0;
      instr_rd  <= 1'b0;
      op_valid  <= 1'b0;
      op_unit   <= '0;
      dst_sel   <= '0;
      dst_addr  <= '0;
      src1_addr <= '0;
      src2_addr <= '0;
      src1_sel  <= 1'b0;
      src2_sel  <= 1'b0;
      scalar    <= '0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      err       <= 1'b0;
      err_code  <= '0;
      retired   <= '0;
`ifdef EXEC_SEQ_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state    <= S_FETCH;
            pc       <= start_pc;
            instr_rd <= 1'b1;
            retired  <= '0;
            halted   <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_FETCH: begin
          if (instr_valid) begin
            instr_q  <= instr_data;
            instr_rd <= 1'b0;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (f_opcode == 4'd0) begin
            state   <= S_HALT;
            halted  <= 1'b1;
            busy    <= 1'b0;
            retired <= retired_inc;
          end else if (f_opcode <= 4'd5) begin
            state    <= S_ISSUE;
            op_valid <= 1'b1;
            op_unit  <= unit_onehot;
            dst_sel  <= f_dst_sel;
            dst_addr <= f_dst_addr;
            if (f_opcode == 4'd4) begin
              src1_sel  <= 1'b0;
              src1_addr <= '0;
              src2_sel  <= 1'b0;
              src2_addr <= '0;
              scalar    <= f_scalar;
            end else begin
              src1_sel  <= f_src1_sel;
              src1_addr <= f_src1_addr;
              src2_sel  <= f_src2_sel;
              src2_addr <= f_src2_addr;
              scalar    <= '0;
            end
          end else begin
            state    <= S_ERR;
            err      <= 1'b1;
            err_code <= 2'd1;
            busy     <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (op_ready) begin
            op_valid <= 1'b0;
            state    <= S_WAIT;
`ifdef EXEC_SEQ_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (op_done) begin
            pc       <= pc + PC_W'(1);
            instr_rd <= 1'b1;
            retired  <= retired_inc;
            state    <= S_FETCH;
          end
`ifdef EXEC_SEQ_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            state    <= S_ERR;
            err      <= 1'b1;
            err_code <= 2'd2;
            op_unit  <= '0;
            busy     <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        default: begin
          // ERR is terminal until reset.
        end
      endcase
    end
  end

endmodule
